mb_spi_bram_port_arbiter: RTL and testbench
===========================================

// Module: mb_spi_bram_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing BRAM port B of the MicroBlaze local-memory block between two fabric requesters:
//   - requester 0: SPI capture writer
//   - requester 1: image readout engine
//  Registers the winning access onto the port, pulses an ack, and returns read data one cycle later.
//  Port A stays owned by the processor LMB and is outside this block.
// PARAMETERS
//  C_MEMSIZE    'h8000  BRAM size in bytes; power of two, >= 8
//  C_BASEADDR   'h0     byte base address of the BRAM window, aligned to C_MEMSIZE
//  C_NUM_WE     4       byte write enables per 32-bit word
// PORTS
//  BRAM_Clk      in   1   sole clock; also drives the BRAM port B clock
//  BRAM_Rst_N    in   1   asynchronous, active-low reset
//  Req0/Req1     in   1   access request, level; held until the matching Ack
//  We0/We1       in   4   byte write enables; 0 = read
//  Addr0/Addr1   in   32  byte address
//  Wdata0/Wdata1 in   32  write data
//  Ack0/Ack1     out  1   1-cycle pulse: access issued (or rejected)
//  Rdata0/Rdata1 out  32  read data, valid while RvalidX=1
//  Rvalid0/Rvalid1 out 1  1-cycle pulse, cycle after AckX for a read
//  Err0/Err1     out  1   pulses with AckX on a rejected access (macro only)
//  BRAM_EN_B     out  1   port enable
//  BRAM_WEN_B    out  4   port byte write enables
//  BRAM_Addr_B   out  32  port byte address
//  BRAM_Dout_B   out  32  write data to BRAM
//  BRAM_Din_B    in   32  read data from BRAM, 1-cycle latency after EN
// BEHAVIOUR
//  - Reset (async assert, sync release): every output is 0, RR pointer favours requester 0, pending read owner is cleared.
//  - Eligibility: ReqX & ~AckX. The cycle in which AckX is high consumes that request; ReqX is not sampled in that cycle.
//  - Issue stage is registered. The winner sampled at edge k gives, for the whole of cycle k+1:
//      * BRAM_EN_B = 1, BRAM_WEN_B = WeX, BRAM_Dout_B = WdataX
//      * BRAM_Addr_B = {C_BASEADDR upper bits, AddrX[log2(C_MEMSIZE)-1:2], 2'b00}
//      * AckX = 1
//  - Idle cycle (no eligible requester): BRAM_EN_B = 0 and BRAM_WEN_B = 0; Addr_B and Dout_B hold their last values.
//  - Read (WeX = 0):
//      * RvalidX = 1 in cycle k+2; RdataX = BRAM_Din_B
//      * RdataX otherwise holds its last value
//  - Write: no Rvalid. Total read latency = 2 cycles from Req sample.
//  - Arbitration:
//      * only one requester eligible: that requester wins
//      * both eligible: the requester not served last wins, then the pointer flips
//      * the pointer updates only on an issue
//  - Throughput: one access per 2 cycles per requester; with both active, grants alternate 0,1,0,1 and the port is busy every cycle.
//  - A read issued at k+1 and another access issued at k+2 are legal; the owner register is pipelined one deep.
//  - Req dropped before Ack: the request is withdrawn; no access and no ack.
//  - Reset mid-operation: an in-flight read is discarded; no Rvalid after reset release.
// CONFIGURATION
//  Macro BRAM_ARB_ADDR_CHECK_EN
//  - Defined: a request with AddrX outside [C_BASEADDR, C_BASEADDR+C_MEMSIZE) or AddrX[1:0] != 0 is rejected:
//      * AckX=1 and ErrX=1 in the issue cycle; BRAM_EN_B=0 and the port is left untouched
//      * if a read, RvalidX pulses next cycle with RdataX = 0
//      * the rejection counts as a grant for RR purposes
//  - Undefined: no check; address wraps modulo C_MEMSIZE, low 2 bits ignored; Err0/Err1 tied to 0.
// TESTING
//  1 Reset: BRAM_Rst_N=0 with Req0=Req1=1 -> all outputs 0; release -> Ack0 on the first issue cycle (RR starts at 0).
//  2 Single write then read:
//      * Req0, We0=F, Addr0=0x10, Wdata0=DEADBEEF -> next cycle: EN_B=1, WEN_B=F, Addr_B=0x10, Ack0=1
//      * then read of 0x10 -> Rvalid0=1, Rdata0=DEADBEEF two cycles after the Req sample
//  3 Contention: Req0, Req1 held for 8 accesses -> Ack order 0,1,0,1..., EN_B high every cycle, no lost or duplicated access.
//  4 Byte write: We1=4'b0010, Wdata1=0x0000AB00 to 0x20 -> readback shows only byte lane 1 changed.
//  5 Async reset asserted one cycle after a read issues -> no Rvalid after release; Ack, EN_B, WEN_B all 0.
//  6 With BRAM_ARB_ADDR_CHECK_EN: read of 0x8000 -> Ack0=1, Err0=1, EN_B=0, next cycle Rvalid0=1, Rdata0=0.
//    Without the macro: the same read accesses word 0.

Source files
------------

// File: rtl/mb_spi_bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port B between the SPI capture writer (0) and image readout (1).
// Optional macro BRAM_ARB_ADDR_CHECK_EN rejects out-of-window or misaligned addresses with an Err pulse.
module mb_spi_bram_port_arbiter #(
  parameter logic [31:0] C_MEMSIZE  = 32'h0000_8000,
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter int          C_NUM_WE   = 4
) (
  input  logic                BRAM_Clk,
  input  logic                BRAM_Rst_N,
  input  logic                Req0,
  input  logic                Req1,
  input  logic [C_NUM_WE-1:0] We0,
  input  logic [C_NUM_WE-1:0] We1,
  input  logic [31:0]         Addr0,
  input  logic [31:0]         Addr1,
  input  logic [31:0]         Wdata0,
  input  logic [31:0]         Wdata1,
  output logic                Ack0,
  output logic                Ack1,
  output logic [31:0]         Rdata0,
  output logic [31:0]         Rdata1,
  output logic                Rvalid0,
  output logic                Rvalid1,
  output logic                Err0,
  output logic                Err1,
  output logic                BRAM_EN_B,
  output logic [C_NUM_WE-1:0] BRAM_WEN_B,
  output logic [31:0]         BRAM_Addr_B,
  output logic [31:0]         BRAM_Dout_B,
  input  logic [31:0]         BRAM_Din_B
);

  localparam int AW = $clog2(C_MEMSIZE);

  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                rr_q, rr_d;
  logic                en_q, en_d;
  logic [C_NUM_WE-1:0] wen_q, wen_d;
  logic [31:0]         addr_q, addr_d, dout_q, dout_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic                rd_pend_q, rd_pend_d, rd_owner_q, rd_owner_d, rd_zero_q, rd_zero_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d, rzero_q, rzero_d;
  logic [31:0]         rhold0_q, rhold0_d, rhold1_q, rhold1_d;

  logic                elig0_s, elig1_s, gnt0_s, gnt1_s, issue_s, sel_s, bad_s, access_s;
  logic [C_NUM_WE-1:0] we_sel_s;
  logic [31:0]         addr_sel_s, wdata_sel_s, port_addr_s, rdata0_s, rdata1_s;

  assign addr_sel_s  = gnt1_s ? Addr1 : Addr0;
  assign port_addr_s = {C_BASEADDR[31:AW], addr_sel_s[AW-1:2], 2'b00};

`ifdef BRAM_ARB_ADDR_CHECK_EN
  assign bad_s = (addr_sel_s[31:AW] != C_BASEADDR[31:AW]) || (addr_sel_s[1:0] != 2'b00);
`else
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{addr_sel_s[31:AW], addr_sel_s[1:0]};
  assign bad_s = 1'b0;
`endif

  // Arbitration: a requester is blocked during its own ack cycle; ties go to whoever was not served last.
  always_comb begin
    elig0_s     = Req0 & ~ack0_q;
    elig1_s     = Req1 & ~ack1_q;
    gnt0_s      = elig0_s & (~elig1_s | ~rr_q);
    gnt1_s      = elig1_s & (~elig0_s | rr_q);
    issue_s     = gnt0_s | gnt1_s;
    sel_s       = gnt1_s;
    we_sel_s    = sel_s ? We1 : We0;
    wdata_sel_s = sel_s ? Wdata1 : Wdata0;
    access_s    = issue_s & ~bad_s;
  end

  // Next-state for the issue stage and the one-deep read owner pipeline.
  always_comb begin
    ack0_d     = gnt0_s;
    ack1_d     = gnt1_s;
    err0_d     = gnt0_s & bad_s;
    err1_d     = gnt1_s & bad_s;
    rd_pend_d  = issue_s & (we_sel_s == {C_NUM_WE{1'b0}});
    rd_owner_d = sel_s;
    rd_zero_d  = bad_s;
    rvalid0_d  = rd_pend_q & ~rd_owner_q;
    rvalid1_d  = rd_pend_q & rd_owner_q;
    rzero_d    = rd_pend_q & rd_zero_q;
    if (issue_s) begin
      rr_d = ~sel_s;
    end else begin
      rr_d = rr_q;
    end
    if (access_s) begin
      en_d   = 1'b1;
      wen_d  = we_sel_s;
      addr_d = port_addr_s;
      dout_d = wdata_sel_s;
    end else begin
      en_d   = 1'b0;
      wen_d  = {C_NUM_WE{1'b0}};
      addr_d = addr_q;
      dout_d = dout_q;
    end
  end

  // BRAM data arrives in the Rvalid cycle itself, so the Rdata ports pass it through and hold it afterwards.
  always_comb begin
    if (rvalid0_q) begin
      rdata0_s = rzero_q ? 32'h0000_0000 : BRAM_Din_B;
    end else begin
      rdata0_s = rhold0_q;
    end
    if (rvalid1_q) begin
      rdata1_s = rzero_q ? 32'h0000_0000 : BRAM_Din_B;
    end else begin
      rdata1_s = rhold1_q;
    end
    rhold0_d = rdata0_s;
    rhold1_d = rdata1_s;
  end

  // State registers.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rr_q       <= 1'b0;
      en_q       <= 1'b0;
      wen_q      <= {C_NUM_WE{1'b0}};
      addr_q     <= 32'h0000_0000;
      dout_q     <= 32'h0000_0000;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_zero_q  <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rzero_q    <= 1'b0;
      rhold0_q   <= 32'h0000_0000;
      rhold1_q   <= 32'h0000_0000;
    end else begin
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rr_q       <= rr_d;
      en_q       <= en_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_zero_q  <= rd_zero_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rzero_q    <= rzero_d;
      rhold0_q   <= rhold0_d;
      rhold1_q   <= rhold1_d;
    end
  end

  assign Ack0        = ack0_q;
  assign Ack1        = ack1_q;
  assign Err0        = err0_q;
  assign Err1        = err1_q;
  assign Rvalid0     = rvalid0_q;
  assign Rvalid1     = rvalid1_q;
  assign Rdata0      = rdata0_s;
  assign Rdata1      = rdata1_s;
  assign BRAM_EN_B   = en_q;
  assign BRAM_WEN_B  = wen_q;
  assign BRAM_Addr_B = addr_q;
  assign BRAM_Dout_B = dout_q;

endmodule

// File: tb/tb_mb_spi_bram_port_arbiter.sv
// Directed bench for mb_spi_bram_port_arbiter with a behavioural BRAM on port B.
module tb_mb_spi_bram_port_arbiter;
  logic        clk, rst_n;
  logic        req0, req1;
  logic [3:0]  we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, rvalid0, rvalid1, err0, err1, en_b;
  logic [31:0] rdata0, rdata1, addr_b, dout_b, din_b;
  logic [3:0]  wen_b;
  logic [31:0] mem [0:8191];
  int checks = 0;
  int errors = 0;

  mb_spi_bram_port_arbiter dut (
    .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
    .Req0(req0), .Req1(req1), .We0(we0), .We1(we1),
    .Addr0(addr0), .Addr1(addr1), .Wdata0(wdata0), .Wdata1(wdata1),
    .Ack0(ack0), .Ack1(ack1), .Rdata0(rdata0), .Rdata1(rdata1),
    .Rvalid0(rvalid0), .Rvalid1(rvalid1), .Err0(err0), .Err1(err1),
    .BRAM_EN_B(en_b), .BRAM_WEN_B(wen_b), .BRAM_Addr_B(addr_b),
    .BRAM_Dout_B(dout_b), .BRAM_Din_B(din_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // read-first BRAM, one cycle read latency
  always @(posedge clk) begin
    if (en_b) begin
      din_b <= mem[addr_b[14:2]];
      for (int b = 0; b < 4; b++)
        if (wen_b[b]) mem[addr_b[14:2]][8*b +: 8] <= dout_b[8*b +: 8];
    end
  end

  // Stimulus only: issues one access, reports what was seen at ack and one cycle later.
  task automatic access(input int port, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic acked, output logic en_at,
                        output logic [31:0] addr_at, output logic err_at,
                        output logic rv, output logic [31:0] rd);
    acked = 1'b0; en_at = 1'b0; addr_at = 32'h0; err_at = 1'b0;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        acked = 1'b1; en_at = en_b; addr_at = addr_b;
        err_at = (port == 0) ? err0 : err1;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    rv = (port == 0) ? rvalid0 : rvalid1;
    rd = (port == 0) ? rdata0 : rdata1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    we0 = 4'h0; we1 = 4'h0; addr0 = 32'h0; addr1 = 32'h4; wdata0 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ack0, ack1, en_b, rvalid0, rvalid1, err0, err1} !== 7'b0)
      begin errors++; $display("FAIL reset_ctl got %b want 0", {ack0, ack1, en_b, rvalid0, rvalid1, err0, err1}); end
    checks++; if ({wen_b, addr_b, dout_b, rdata0, rdata1} !== 132'b0)
      begin errors++; $display("FAIL reset_data got wen=%h addr=%h dout=%h rd0=%h rd1=%h want 0", wen_b, addr_b, dout_b, rdata0, rdata1); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ack0, ack1, en_b} !== 3'b101)
      begin errors++; $display("FAIL reset_first_grant got ack0,ack1,en=%b want 101", {ack0, ack1, en_b}); end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    checks++; if ({ack0, ack1, en_b, wen_b} !== 7'b0)
      begin errors++; $display("FAIL withdraw_idle got %b want 0", {ack0, ack1, en_b, wen_b}); end
    checks++; if (rvalid0 !== 1'b1)
      begin errors++; $display("FAIL reset_read_rvalid got %b want 1", rvalid0); end
  endtask

  task automatic test_write_read;
    req0 = 1'b1; we0 = 4'hF; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    @(posedge clk); #1;
    checks++; if ({ack0, en_b, wen_b} !== 6'b11_1111 || addr_b !== 32'h10 || dout_b !== 32'hDEADBEEF)
      begin errors++; $display("FAIL write_issue got ack=%b en=%b wen=%h addr=%h dout=%h want 1 1 f 10 deadbeef", ack0, en_b, wen_b, addr_b, dout_b); end
    we0 = 4'h0;
    @(posedge clk); #1;
    checks++; if ({ack0, en_b, wen_b, rvalid0} !== 7'b0 || addr_b !== 32'h10)
      begin errors++; $display("FAIL ack_cycle_gap got ack=%b en=%b wen=%h rv=%b addr=%h want 0 0 0 0 10", ack0, en_b, wen_b, rvalid0, addr_b); end
    @(posedge clk); #1;
    checks++; if ({ack0, en_b, wen_b} !== 6'b11_0000)
      begin errors++; $display("FAIL read_issue got ack=%b en=%b wen=%h want 1 1 0", ack0, en_b, wen_b); end
    req0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF)
      begin errors++; $display("FAIL read_data got rv=%b rd=%h want 1 deadbeef", rvalid0, rdata0); end
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 32'hDEADBEEF)
      begin errors++; $display("FAIL rdata_hold got rv=%b rd=%h want 0 deadbeef", rvalid0, rdata0); end
  endtask

  task automatic test_contention;
    int idx0, idx1;
    logic exp1;
    logic [31:0] ea, ed;
    idx0 = 0; idx1 = 0; exp1 = 1'b1;  // requester 0 was served last
    req0 = 1'b1; we0 = 4'hF; addr0 = 32'h100; wdata0 = 32'hA000_0000;
    req1 = 1'b1; we1 = 4'hF; addr1 = 32'h104; wdata1 = 32'hB000_0000;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      ea = exp1 ? (32'h104 + 32'(8 * idx1)) : (32'h100 + 32'(8 * idx0));
      ed = exp1 ? (32'hB000_0000 + 32'(idx1)) : (32'hA000_0000 + 32'(idx0));
      checks++; if (en_b !== 1'b1 || {ack1, ack0} !== (exp1 ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL rr_order[%0d] got en=%b ack1,ack0=%b want 1 %b", c, en_b, {ack1, ack0}, exp1 ? 2'b10 : 2'b01); end
      checks++; if (addr_b !== ea || dout_b !== ed)
        begin errors++; $display("FAIL rr_access[%0d] got addr=%h dout=%h want %h %h", c, addr_b, dout_b, ea, ed); end
      if (exp1) begin
        idx1++; addr1 = 32'h104 + 32'(8 * idx1); wdata1 = 32'hB000_0000 + 32'(idx1);
        if (idx1 == 4) req1 = 1'b0;
      end else begin
        idx0++; addr0 = 32'h100 + 32'(8 * idx0); wdata0 = 32'hA000_0000 + 32'(idx0);
        if (idx0 == 4) req0 = 1'b0;
      end
      exp1 = ~exp1;
    end
    @(posedge clk); #1;
    checks++; if ({ack0, ack1, en_b} !== 3'b0)
      begin errors++; $display("FAIL rr_no_extra got %b want 0", {ack0, ack1, en_b}); end
  endtask

  task automatic test_back_to_back_readback;
    logic a, e, er, rv; logic [31:0] ad, rd;
    access(0, 4'h0, 32'h118, 32'h0, a, e, ad, er, rv, rd);
    checks++; if (a !== 1'b1 || rv !== 1'b1 || rd !== 32'hA000_0003)
      begin errors++; $display("FAIL readback0 got ack=%b rv=%b rd=%h want 1 1 a0000003", a, rv, rd); end
    access(1, 4'h0, 32'h11C, 32'h0, a, e, ad, er, rv, rd);
    checks++; if (a !== 1'b1 || rv !== 1'b1 || rd !== 32'hB000_0003)
      begin errors++; $display("FAIL readback1 got ack=%b rv=%b rd=%h want 1 1 b0000003", a, rv, rd); end
  endtask

  task automatic test_byte_write;
    logic a, e, er, rv; logic [31:0] ad, rd;
    access(1, 4'hF, 32'h20, 32'h1122_3344, a, e, ad, er, rv, rd);
    checks++; if (a !== 1'b1 || rv !== 1'b0)
      begin errors++; $display("FAIL byte_prefill got ack=%b rv=%b want 1 0", a, rv); end
    access(1, 4'b0010, 32'h20, 32'h0000_AB00, a, e, ad, er, rv, rd);
    access(1, 4'h0, 32'h20, 32'h0, a, e, ad, er, rv, rd);
    checks++; if (a !== 1'b1 || rv !== 1'b1 || rd !== 32'h1122_AB44)
      begin errors++; $display("FAIL byte_lane1 got ack=%b rv=%b rd=%h want 1 1 1122ab44", a, rv, rd); end
  endtask

  task automatic test_reset_midflight;
    req0 = 1'b1; we0 = 4'h0; addr0 = 32'h10;
    @(posedge clk); #1;
    checks++; if (ack0 !== 1'b1)
      begin errors++; $display("FAIL mid_read_issue got ack0=%b want 1", ack0); end
    #2; rst_n = 1'b0; req0 = 1'b0;
    #1;
    checks++; if ({ack0, en_b, wen_b, rvalid0} !== 7'b0)
      begin errors++; $display("FAIL mid_async_clear got %b want 0", {ack0, en_b, wen_b, rvalid0}); end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if ({ack0, ack1, en_b, wen_b, rvalid0, rvalid1} !== 9'b0 || rdata0 !== 32'h0)
        begin errors++; $display("FAIL mid_no_rvalid[%0d] got ctl=%b rd0=%h want 0 0", i, {ack0, ack1, en_b, wen_b, rvalid0, rvalid1}, rdata0); end
    end
  endtask

  task automatic test_addr_range;
    logic a, e, er, rv; logic [31:0] ad, rd;
    access(1, 4'hF, 32'h0, 32'hCAFE_F00D, a, e, ad, er, rv, rd);
    access(0, 4'h0, 32'h8000, 32'h0, a, e, ad, er, rv, rd);
`ifdef BRAM_ARB_ADDR_CHECK_EN
    checks++; if ({a, er, e} !== 3'b110)
      begin errors++; $display("FAIL oob_reject got ack,err,en=%b want 110", {a, er, e}); end
    checks++; if (rv !== 1'b1 || rd !== 32'h0)
      begin errors++; $display("FAIL oob_rdata got rv=%b rd=%h want 1 0", rv, rd); end
`else
    checks++; if ({a, er, e} !== 3'b101 || ad !== 32'h0)
      begin errors++; $display("FAIL wrap_issue got ack,err,en=%b addr=%h want 101 0", {a, er, e}, ad); end
    checks++; if (rv !== 1'b1 || rd !== 32'hCAFE_F00D)
      begin errors++; $display("FAIL wrap_rdata got rv=%b rd=%h want 1 cafef00d", rv, rd); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    din_b = 32'h0;
    test_reset();
    test_write_read();
    test_contention();
    test_back_to_back_readback();
    test_byte_write();
    test_reset_midflight();
    test_addr_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
